refund_dispenser: RTL and testbench

//   Downstream of the money/state update stage of the selling machine. On a refund

---
 rtl/refund_dispenser.sv | 207 ++++++++++++++++++++
 tb/tb_refund_dispenser.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/refund_dispenser.sv
// refund_dispenser
//   Pays out a refund amount (units of 0.1 yuan) as physical coins: 5.0, 1.0 and 0.5
//   yuan. Coins are paid greedily, largest first, from finite per-denomination stock.
//   Each coin is one PULSE_CYCLES-long pulse on its ejector drive, followed by
//   GAP_CYCLES idle cycles.
//
// Ports
//   clk     system clock
//   rst_n   asynchronous reset, active low
//   start   1-cycle pulse, begins a payout (sampled only when idle)
//   amount  refund amount x0.1 yuan, sampled with start, clamped to 999
//   refill  1-cycle pulse, reloads all stocks (honoured only when idle)
//   busy    high from the cycle after an accepted start until the payout ends
//   coin50  ejector drive, 5.0 yuan
//   coin10  ejector drive, 1.0 yuan
//   coin05  ejector drive, 0.5 yuan
//   done    1-cycle pulse at the end of a payout
//   short   payout ended with an unpaid remainder; held until the next accepted start
//   remain  amount still owed
//   empty   {stock50 == 0, stock10 == 0, stock05 == 0}

module refund_dispenser #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned STOCK50_INIT = 20,
    parameter int unsigned STOCK10_INIT = 50,
    parameter int unsigned STOCK05_INIT = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] amount,
    input  logic       refill,
    output logic       busy,
    output logic       coin50,
    output logic       coin10,
    output logic       coin05,
    output logic       done,
    output logic       short,
    output logic [9:0] remain,
    output logic [2:0] empty
);

    // Counter sized to hold the longer of the pulse and gap phases.
    localparam int unsigned CntMax = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);

    localparam logic [7:0] Stock50Init = 8'(STOCK50_INIT);
    localparam logic [7:0] Stock10Init = 8'(STOCK10_INIT);
    localparam logic [7:0] Stock05Init = 8'(STOCK05_INIT);

    localparam logic [9:0] MaxAmount = 10'd999;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StPulse,
        StGap,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        CoinNone,
        Coin50,
        Coin10,
        Coin05
    } coin_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      stock50_q;
    logic [7:0]      stock10_q;
    logic [7:0]      stock05_q;
    logic [9:0]      remain_q;
    logic            busy_q;
    logic            coin50_q;
    logic            coin10_q;
    logic            coin05_q;
    logic            done_q;
    logic            short_q;

    coin_e           pick;
    logic [9:0]      amount_clamped;

    assign amount_clamped = (amount > MaxAmount) ? MaxAmount : amount;

    // Greedy choice for the next coin; a denomination with no stock falls through
    // to the next smaller one.
    always_comb begin
        pick = CoinNone;
        if (remain_q >= 10'd50 && stock50_q != 8'd0) begin
            pick = Coin50;
        end else if (remain_q >= 10'd10 && stock10_q != 8'd0) begin
            pick = Coin10;
        end else if (remain_q >= 10'd5 && stock05_q != 8'd0) begin
            pick = Coin05;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            stock50_q <= Stock50Init;
            stock10_q <= Stock10Init;
            stock05_q <= Stock05Init;
            remain_q  <= '0;
            busy_q    <= 1'b0;
            coin50_q  <= 1'b0;
            coin10_q  <= 1'b0;
            coin05_q  <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A refill in the same cycle as start lands first, so the new
                    // payout sees full stock.
                    if (refill) begin
                        stock50_q <= Stock50Init;
                        stock10_q <= Stock10Init;
                        stock05_q <= Stock05Init;
                    end
                    if (start) begin
                        remain_q <= amount_clamped;
                        short_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StSelect;
                    end
                end

                StSelect: begin
                    cnt_q <= '0;
                    case (pick)
                        Coin50: begin
                            remain_q  <= remain_q - 10'd50;
                            stock50_q <= stock50_q - 8'd1;
                            coin50_q  <= 1'b1;
                            state_q   <= StPulse;
                        end
                        Coin10: begin
                            remain_q  <= remain_q - 10'd10;
                            stock10_q <= stock10_q - 8'd1;
                            coin10_q  <= 1'b1;
                            state_q   <= StPulse;
                        end
                        Coin05: begin
                            remain_q  <= remain_q - 10'd5;
                            stock05_q <= stock05_q - 8'd1;
                            coin05_q  <= 1'b1;
                            state_q   <= StPulse;
                        end
                        default: begin
                            done_q  <= 1'b1;
                            short_q <= (remain_q != 10'd0);
                            state_q <= StDone;
                        end
                    endcase
                end

                StPulse: begin
                    if (cnt_q == PulseLast) begin
                        coin50_q <= 1'b0;
                        coin10_q <= 1'b0;
                        coin05_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StGap;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_q   <= '0;
                        state_q <= StSelect;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign coin50 = coin50_q;
    assign coin10 = coin10_q;
    assign coin05 = coin05_q;
    assign done   = done_q;
    assign short  = short_q;
    assign remain = remain_q;
    assign empty  = {stock50_q == 8'd0, stock10_q == 8'd0, stock05_q == 8'd0};

endmodule

// File: tb/tb_refund_dispenser.sv
// Scoreboard bench for refund_dispenser: stimulus pushes the expected coin/done
// events into a queue; a negedge monitor pops and compares them as the DUT emits.
module tb_refund_dispenser;

    localparam int PULSE  = 4;
    localparam int GAP    = 4;
    localparam int PERIOD = 1 + PULSE + GAP;
    localparam int KDONE  = -1;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       refill = 1'b0;
    logic [9:0] amount = 10'd0;
    logic       busy;
    logic       coin50;
    logic       coin10;
    logic       coin05;
    logic       done;
    logic       short_flag;
    logic [9:0] remain;
    logic [2:0] empty;

    refund_dispenser #(
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES  (GAP),
        .STOCK50_INIT(20),
        .STOCK10_INIT(50),
        .STOCK05_INIT(50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .amount(amount),
        .refill(refill),
        .busy  (busy),
        .coin50(coin50),
        .coin10(coin10),
        .coin05(coin05),
        .done  (done),
        .short (short_flag),
        .remain(remain),
        .empty (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int rem;
        int sh;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    function void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endfunction

    function void push_ev(int kind, int rem, int sh);
        ev_t e;
        e.kind = kind;
        e.rem  = rem;
        e.sh   = sh;
        exp_q.push_back(e);
    endfunction

    function void push_coins(int n50, int n10, int n05);
        for (int i = 0; i < n50; i++) push_ev(50, 0, 0);
        for (int i = 0; i < n10; i++) push_ev(10, 0, 0);
        for (int i = 0; i < n05; i++) push_ev(5, 0, 0);
    endfunction

    // Monitor
    int         cyc       = 0;
    int         run_len   = 0;
    int         last_rise = 0;
    bit         have_rise = 1'b0;
    logic [2:0] prev      = 3'b000;

    always @(negedge clk) begin
        logic [2:0] cur;
        int         kind;
        ev_t        e;
        cyc++;
        if (!rst_n) begin
            run_len   = 0;
            prev      = 3'b000;
            have_rise = 1'b0;
        end else begin
            cur = {coin50, coin10, coin05};
            if ($countones(cur) > 1) chk("coin_onehot", $countones(cur), 1);
            if (cur != 3'b000 && prev == 3'b000) begin
                kind = cur[2] ? 50 : (cur[1] ? 10 : 5);
                if (have_rise) chk("coin_period", cyc - last_rise, PERIOD);
                last_rise = cyc;
                have_rise = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("coin_unexpected", kind, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("coin_kind", kind, e.kind);
                end
            end
            if (cur != 3'b000) begin
                run_len++;
            end else if (prev != 3'b000) begin
                chk("pulse_width", run_len, PULSE);
                run_len = 0;
            end
            if (done) begin
                have_rise = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", KDONE, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_order", KDONE, e.kind);
                    chk("done_remain", int'(remain), e.rem);
                    chk("done_short", int'(short_flag), e.sh);
                end
            end
            prev = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int a);
        amount = 10'(a);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        chk("done_seen", int'(done === 1'b1), 1);
        tick();
    endtask

    task automatic do_refill();
        refill = 1'b1;
        tick();
        refill = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_coins", int'({coin50, coin10, coin05}), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short_flag), 0);
        chk("rst_remain", int'(remain), 0);
        chk("rst_empty", int'(empty), 0);
        rst_n = 1'b1;
        tick();

        // 1: 65 -> 50, 10, 05
        push_coins(1, 1, 1);
        push_ev(KDONE, 0, 0);
        issue(65);
        chk("t1_busy", int'(busy), 1);
        lat = 1;
        while (coin50 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("t1_first_coin_latency", lat, 2);
        wait_done();
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_remain", int'(remain), 0);

        // 2: zero amount
        push_ev(KDONE, 0, 0);
        issue(0);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("t2_done_latency", lat, 2);
        tick();
        chk("t2_busy_after", int'(busy), 0);

        // 3: drain stock50 to 1, then 105
        do_refill();
        push_coins(19, 0, 0);
        push_ev(KDONE, 0, 0);
        issue(950);
        wait_done();
        chk("t3_empty_mid", int'(empty), 0);
        push_coins(1, 5, 1);
        push_ev(KDONE, 0, 0);
        issue(105);
        wait_done();
        chk("t3_empty", int'(empty), 3'b100);

        // 4: drain stock05 (49 left), then 15
        for (int i = 0; i < 49; i++) begin
            push_coins(0, 0, 1);
            push_ev(KDONE, 0, 0);
            issue(5);
            wait_done();
        end
        chk("t4_empty_drained", int'(empty), 3'b101);
        push_coins(0, 1, 0);
        push_ev(KDONE, 5, 1);
        issue(15);
        wait_done();
        tick();
        tick();
        chk("t4_short_held", int'(short_flag), 1);
        chk("t4_remain_held", int'(remain), 5);

        // 5: clamp 1023 -> 999, with an ignored start+refill mid-payout
        do_refill();
        push_coins(19, 4, 1);
        push_ev(KDONE, 4, 1);
        issue(1023);
        chk("t5_short_cleared", int'(short_flag), 0);
        chk("t5_remain_clamped", int'(remain), 999);
        repeat (30) tick();
        amount = 10'd5;
        start  = 1'b1;
        refill = 1'b1;
        tick();
        start  = 1'b0;
        refill = 1'b0;
        chk("t5_busy_mid", int'(busy), 1);
        wait_done();
        chk("t5_empty", int'(empty), 0);
        // Only one 5.0 coin is left if the mid-payout refill was ignored.
        push_coins(1, 5, 1);
        push_ev(KDONE, 0, 0);
        issue(105);
        wait_done();
        chk("t5_empty_after", int'(empty), 3'b100);

        // 6: reset during a coin10 pulse
        push_coins(0, 1, 0);
        issue(65);
        n = 0;
        while (coin10 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_coin10_seen", int'(coin10), 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_coin10_drop", int'(coin10), 0);
        chk("t6_busy_drop", int'(busy), 0);
        chk("t6_remain_drop", int'(remain), 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_empty_reloaded", int'(empty), 0);
        push_coins(1, 1, 1);
        push_ev(KDONE, 0, 0);
        issue(65);
        wait_done();

        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
